// File: rtl/m68k_bus_responder.sv
// 68000 async-bus target: a word register window that ends each bus
// cycle with DTACK after a set number of wait states, or with BERR.
//
// Ports:
//   PI_CLK, RESET        clock; synchronous active-high reset
//   M68K_A[23:1]         bus word address, read while AS is low
//   M68K_AS_n/UDS_n/LDS_n/RW  async bus strobes and direction
//   M68K_D_IN/D_OUT/D_OE write data in; read data out with drive enable
//   M68K_DTACK_n/BERR_n  cycle termination, active low
//   HOST_ADDR/HOST_RDATA side-port register inspection, 1-cycle latency
//   ACK_CNT/BERR_CNT     wrapping counts of terminated cycles
module m68k_bus_responder #(
    parameter logic [23:0] BASE_ADDR   = 24'hE80000,
    parameter int          ADDR_W      = 4,
    parameter int          WAIT_CYCLES = 4,
    parameter int          TIMEOUT     = 1023
) (
    input  logic              PI_CLK,
    input  logic              RESET,
    input  logic [23:1]       M68K_A,
    input  logic              M68K_AS_n,
    input  logic              M68K_UDS_n,
    input  logic              M68K_LDS_n,
    input  logic              M68K_RW,
    input  logic [15:0]       M68K_D_IN,
    output logic [15:0]       M68K_D_OUT,
    output logic              M68K_D_OE,
    output logic              M68K_DTACK_n,
    output logic              M68K_BERR_n,
    input  logic [ADDR_W-1:0] HOST_ADDR,
    output logic [15:0]       HOST_RDATA,
    output logic [15:0]       ACK_CNT,
    output logic [15:0]       BERR_CNT
);

    localparam int WORDS = 2 ** ADDR_W;
    localparam logic [9:0] WAIT_M1 = 10'(WAIT_CYCLES - 1);
    localparam logic [9:0] TO_LIM  = 10'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_WAIT,
        S_ACK,
        S_BERR,
        S_RELEASE
    } state_t;

    state_t state;

    logic              as_m;
    logic              as_s;
    logic [1:0]        ds_m;
    logic [1:0]        ds_s;
    logic              rw_m;
    logic              rw_s;
    logic              pend;
    logic              rw_l;
    logic [ADDR_W-1:0] idx;
    logic [9:0]        cnt;
    logic [15:0]       regs [WORDS];

    logic fall;
    logic hit;
    logic ds_any;
    logic wait_ok;

    // as_s still high while the first stage already shows low: this
    // edge is where the synchronized strobe first reads low.
    assign fall    = as_s & ~as_m;
    assign hit     = M68K_A[23:ADDR_W+1] == BASE_ADDR[23:ADDR_W+1];
    assign ds_any  = ds_s != 2'b11;
    assign wait_ok = cnt >= WAIT_M1;

    always_ff @(posedge PI_CLK) begin
        if (RESET) begin
            // Sync flops reset low so an AS already low at reset exit
            // does not look like a fresh falling edge.
            as_m         <= 1'b0;
            as_s         <= 1'b0;
            ds_m         <= 2'b11;
            ds_s         <= 2'b11;
            rw_m         <= 1'b1;
            rw_s         <= 1'b1;
            state        <= S_IDLE;
            pend         <= 1'b0;
            rw_l         <= 1'b1;
            idx          <= '0;
            cnt          <= '0;
            M68K_D_OUT   <= '0;
            M68K_D_OE    <= 1'b0;
            M68K_DTACK_n <= 1'b1;
            M68K_BERR_n  <= 1'b1;
            HOST_RDATA   <= '0;
            ACK_CNT      <= '0;
            BERR_CNT     <= '0;
            for (int i = 0; i < WORDS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            as_m       <= M68K_AS_n;
            as_s       <= as_m;
            ds_m       <= {M68K_UDS_n, M68K_LDS_n};
            ds_s       <= ds_m;
            rw_m       <= M68K_RW;
            rw_s       <= rw_m;
            HOST_RDATA <= regs[HOST_ADDR];

            unique case (state)
                S_IDLE: begin
                    pend <= 1'b0;
                    if (fall || (pend && !as_s)) begin
                        state <= S_DECODE;
                    end
                end

                S_DECODE: begin
                    idx  <= M68K_A[ADDR_W:1];
                    rw_l <= rw_s;
                    cnt  <= '0;
                    if (hit) begin
                        state <= S_WAIT;
                    end else begin
                        state       <= S_BERR;
                        M68K_BERR_n <= 1'b0;
                        BERR_CNT    <= BERR_CNT + 16'd1;
                    end
                end

                S_WAIT: begin
                    if (as_s) begin
                        // Master gave up: quietly drop the cycle.
                        state <= S_IDLE;
                    end else if (wait_ok && ds_any) begin
                        state        <= S_ACK;
                        M68K_DTACK_n <= 1'b0;
                        M68K_D_OE    <= rw_l;
                        ACK_CNT      <= ACK_CNT + 16'd1;
                        if (rw_l) begin
                            M68K_D_OUT <= regs[idx];
                        end else begin
                            if (!ds_s[1]) begin
                                regs[idx][15:8] <= M68K_D_IN[15:8];
                            end
                            if (!ds_s[0]) begin
                                regs[idx][7:0] <= M68K_D_IN[7:0];
                            end
                        end
                    end else if (cnt >= TO_LIM) begin
                        state       <= S_BERR;
                        M68K_BERR_n <= 1'b0;
                        BERR_CNT    <= BERR_CNT + 16'd1;
                    end else if (cnt != 10'h3FF) begin
                        cnt <= cnt + 10'd1;
                    end
                end

                S_ACK, S_BERR: begin
                    if (as_s) begin
                        state        <= S_RELEASE;
                        M68K_DTACK_n <= 1'b1;
                        M68K_BERR_n  <= 1'b1;
                        M68K_D_OE    <= 1'b0;
                    end
                end

                S_RELEASE: begin
                    // Remember a new AS fall so IDLE can take it next.
                    pend  <= fall;
                    state <= S_IDLE;
                end

                default: begin
                    state        <= S_IDLE;
                    M68K_DTACK_n <= 1'b1;
                    M68K_BERR_n  <= 1'b1;
                    M68K_D_OE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_responder.sv
// Scoreboard bench for m68k_bus_responder: bus cycles push expected
// responses, the termination strobe pops and compares them.
module tb_m68k_bus_responder;

    localparam logic [23:0] BASE = 24'hE80000;
    localparam int W  = 4;
    localparam int TO = 1023;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:1] a;
    logic        as_n, uds_n, lds_n, rw;
    logic [15:0] d_in;
    logic [3:0]  host_addr;

    logic [15:0] d_out, host_rdata, ack_cnt, berr_cnt;
    logic        d_oe, dtack_n, berr_n;
    logic [15:0] d_out1, host_rdata1, ack_cnt1, berr_cnt1;
    logic        d_oe1, dtack_n1, berr_n1;

    always #5 clk = ~clk;

    m68k_bus_responder #(
        .BASE_ADDR(BASE), .ADDR_W(4), .WAIT_CYCLES(W), .TIMEOUT(TO)
    ) dut (
        .PI_CLK(clk), .RESET(rst), .M68K_A(a), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .M68K_D_IN(d_in), .M68K_D_OUT(d_out), .M68K_D_OE(d_oe),
        .M68K_DTACK_n(dtack_n), .M68K_BERR_n(berr_n),
        .HOST_ADDR(host_addr), .HOST_RDATA(host_rdata),
        .ACK_CNT(ack_cnt), .BERR_CNT(berr_cnt)
    );

    m68k_bus_responder #(
        .BASE_ADDR(BASE), .ADDR_W(4), .WAIT_CYCLES(1), .TIMEOUT(TO)
    ) dut1 (
        .PI_CLK(clk), .RESET(rst), .M68K_A(a), .M68K_AS_n(as_n),
        .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n), .M68K_RW(rw),
        .M68K_D_IN(d_in), .M68K_D_OUT(d_out1), .M68K_D_OE(d_oe1),
        .M68K_DTACK_n(dtack_n1), .M68K_BERR_n(berr_n1),
        .HOST_ADDR(host_addr), .HOST_RDATA(host_rdata1),
        .ACK_CNT(ack_cnt1), .BERR_CNT(berr_cnt1)
    );

    typedef struct packed {
        logic        berr;
        logic        rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] mdl [16];
    int          n_ack = 0;
    int          n_berr = 0;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // u/l: 1 = assert that data strobe.
    task automatic bus_cycle(input logic rw_i, input logic [23:0] addr,
                             input logic u, input logic l,
                             input logic [15:0] wd, input int lim);
        exp_t       e;
        logic       hit;
        logic [3:0] ix;
        int         n, n1;
        bit         done, rel;
        hit = addr[23:5] == BASE[23:5];
        ix  = addr[4:1];
        e.berr = !(hit && (u || l));
        e.rd   = rw_i && !e.berr;
        e.data = mdl[ix];
        if (!e.berr && !rw_i) begin
            if (u) mdl[ix][15:8] = wd[15:8];
            if (l) mdl[ix][7:0]  = wd[7:0];
        end
        if (e.berr) n_berr++;
        else n_ack++;
        sb.push_back(e);

        @(negedge clk);
        a = addr[23:1]; rw = rw_i; d_in = wd;
        as_n = 1'b0; uds_n = !u; lds_n = !l;
        n = 0; n1 = 0; done = 0;
        while (!done && n < lim) begin
            @(negedge clk);
            n++;
            if (n1 == 0 && !dtack_n1) n1 = n;
            if (!dtack_n || !berr_n) done = 1;
        end
        chk("resp_seen", 32'(done), 1);
        e = sb.pop_front();
        if (done) begin
            chk("berr", 32'(!berr_n), 32'(e.berr));
            chk("dtack", 32'(!dtack_n), 32'(!e.berr));
            chk("oe", 32'(d_oe), 32'(e.rd));
            if (e.rd) chk("rdata", 32'(d_out), 32'(e.data));
            if (!e.berr) begin
                chk("lat", n, 3 + W);
                chk("lat_w1", n1, 4);
            end else if (!hit) begin
                chk("miss_lat", n, 3);
            end else begin
                chk("to_lat", n, 4 + TO);
            end
        end
        @(negedge clk);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        rel = 0;
        for (int i = 0; i < 10 && !rel; i++) begin
            @(negedge clk);
            if (dtack_n && berr_n && dtack_n1 && berr_n1 && !d_oe) rel = 1;
        end
        chk("release", 32'(rel), 1);
        repeat (2) @(negedge clk);
        chk("ack_cnt", 32'(ack_cnt), 32'(n_ack));
        chk("berr_cnt", 32'(berr_cnt), 32'(n_berr));
    endtask

    task automatic host_chk(input logic [3:0] ix, input string tag);
        host_addr = ix;
        repeat (2) @(negedge clk);
        chk(tag, 32'(host_rdata), 32'(mdl[ix]));
    endtask

    initial begin : main
        bit         seen, done;
        int         n;
        logic [15:0] v;
        rst = 1'b1; a = '0; as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        rw = 1'b1; d_in = '0; host_addr = '0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        repeat (5) @(negedge clk);
        chk("rst_dtack", 32'(dtack_n), 1);
        chk("rst_berr", 32'(berr_n), 1);
        chk("rst_oe", 32'(d_oe), 0);
        chk("rst_dout", 32'(d_out), 0);
        chk("rst_host", 32'(host_rdata), 0);
        chk("rst_acnt", 32'(ack_cnt), 0);
        chk("rst_bcnt", 32'(berr_cnt), 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        bus_cycle(1'b0, 24'hE80004, 1, 1, 16'hBEEF, 40);
        bus_cycle(1'b1, 24'hE80004, 1, 1, 16'h0000, 40);
        host_chk(4'd2, "host_beef");
        bus_cycle(1'b0, 24'hE80004, 1, 0, 16'h12AA, 40);
        host_chk(4'd2, "host_12ef");
        bus_cycle(1'b0, 24'hE80004, 0, 1, 16'hBB34, 40);
        host_chk(4'd2, "host_1234");

        for (int i = 0; i < 4; i++) begin
            v = 16'($urandom);
            bus_cycle(1'b0, BASE + 24'(2 * (i + 10)), 1, 1, v, 40);
            bus_cycle(1'b1, BASE + 24'(2 * (i + 10)), i[0], !i[0], 0, 40);
        end
        bus_cycle(1'b1, 24'hE8001E, 1, 1, 16'h0000, 40);

        bus_cycle(1'b1, 24'h000000, 1, 1, 16'h0000, 40);
        bus_cycle(1'b0, 24'hE90004, 1, 1, 16'hDEAD, 40);
        bus_cycle(1'b0, 24'hE80004, 0, 0, 16'hFFFF, 1100);
        host_chk(4'd2, "host_after_to");

        // AS withdrawn while waiting for a data strobe.
        @(negedge clk);
        a = 23'(24'hE80004 >> 1); rw = 1'b0; as_n = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!dtack_n || !berr_n) seen = 1;
        end
        as_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (!dtack_n || !berr_n) seen = 1;
        end
        chk("abort_resp", 32'(seen), 0);
        chk("abort_acnt", 32'(ack_cnt), 32'(n_ack));
        chk("abort_bcnt", 32'(berr_cnt), 32'(n_berr));

        for (int i = 0; i < 6; i++)
            bus_cycle(1'b1, BASE + 24'(2 * i), 1, 1, 16'h0000, 40);

        // Reset while DTACK is held.
        @(negedge clk);
        a = 23'(24'hE80004 >> 1); rw = 1'b1;
        as_n = 1'b0; uds_n = 1'b0; lds_n = 1'b0;
        done = 0; n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (!dtack_n) done = 1;
        end
        chk("rst_ack_seen", 32'(done), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rstack_dtack", 32'(dtack_n), 1);
        chk("rstack_oe", 32'(d_oe), 0);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        n_ack = 0; n_berr = 0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (!dtack_n || !berr_n) seen = 1;
        end
        chk("rstack_noresp", 32'(seen), 0);
        chk("rstack_acnt", 32'(ack_cnt), 0);
        as_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
        repeat (5) @(negedge clk);
        bus_cycle(1'b1, 24'hE80004, 1, 1, 16'h0000, 40);
        bus_cycle(1'b0, 24'hE80006, 1, 1, 16'hA5C3, 40);
        host_chk(4'd3, "host_post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
